// File: rtl/scan_mux_n.sv
// Registered N-channel W-bit mux with manual select or prescaled round-robin auto scan.
// Latency 1 cycle from din/sel_in to outputs; no backpressure, outputs update every edge.
module scan_mux_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DIV_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [DIV_W-1:0]          div_val,
    input  logic                      freeze,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          sel_out,
    output logic [CHANNELS-1:0]       chan_onehot,
    output logic                      wrap,
    output logic                      sel_err
);

    localparam logic [SEL_W:0]   CHAN_LIM = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0]    r_sel;
    logic [DIV_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_dout;
    logic [CHANNELS-1:0] r_onehot;
    logic                r_wrap;
    logic                r_sel_err;

    logic                w_sel_ok;
    logic [SEL_W-1:0]    w_sel_next;
    logic [DIV_W-1:0]    w_cnt_next;
    logic                w_wrap_next;
    logic                w_err_next;
    logic [WIDTH-1:0]    w_dout_next;
    logic [CHANNELS-1:0] w_onehot_next;

    // Widened compare so CHANNELS == 2**SEL_W never overflows the limit constant.
    assign w_sel_ok = ({1'b0, sel_in} < CHAN_LIM);

    always_comb begin
        w_sel_next  = r_sel;
        w_cnt_next  = r_cnt;
        w_wrap_next = 1'b0;
        w_err_next  = 1'b0;
        if (!mode) begin
            w_cnt_next = '0;
            if (w_sel_ok) begin
                w_sel_next = sel_in;
            end else begin
                w_err_next = 1'b1;
            end
        end else if (!freeze) begin
            if (r_cnt >= div_val) begin
                w_cnt_next = '0;
                if (r_sel == LAST_CH) begin
                    w_sel_next  = '0;
                    w_wrap_next = 1'b1;
                end else begin
                    w_sel_next = r_sel + 1'b1;
                end
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    // Constant-index decode keeps every slice in range for non-power-of-two counts.
    always_comb begin
        w_dout_next   = '0;
        w_onehot_next = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_sel_next == SEL_W'(k)) begin
                w_dout_next      = din[k*WIDTH +: WIDTH];
                w_onehot_next[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel     <= '0;
            r_cnt     <= '0;
            r_dout    <= '0;
            r_onehot  <= CHANNELS'(1);
            r_wrap    <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_sel     <= w_sel_next;
            r_cnt     <= w_cnt_next;
            r_dout    <= w_dout_next;
            r_onehot  <= w_onehot_next;
            r_wrap    <= w_wrap_next;
            r_sel_err <= w_err_next;
        end
    end

    assign dout        = r_dout;
    assign sel_out     = r_sel;
    assign chan_onehot = r_onehot;
    assign wrap        = r_wrap;
    assign sel_err     = r_sel_err;

endmodule

// File: tb/tb_scan_mux_n.sv
// Directed bench for scan_mux_n: three instances cover 8, 6 and 5 channel configurations.
module tb_scan_mux_n;

    logic clk;
    logic rst;

    logic        mode8, freeze8;
    logic [2:0]  sel_in8;
    logic [15:0] div8;
    logic [63:0] din8;
    logic [7:0]  dout8;
    logic [2:0]  sel8;
    logic [7:0]  oh8;
    logic        wrap8, err8;

    logic        mode6, freeze6;
    logic [2:0]  sel_in6;
    logic [15:0] div6;
    logic [47:0] din6;
    logic [7:0]  dout6;
    logic [2:0]  sel6;
    logic [5:0]  oh6;
    logic        wrap6, err6;

    logic        mode5, freeze5;
    logic [2:0]  sel_in5;
    logic [15:0] div5;
    logic [39:0] din5;
    logic [7:0]  dout5;
    logic [2:0]  sel5;
    logic [4:0]  oh5;
    logic        wrap5, err5;

    int n_checks = 0;
    int n_errors = 0;

    scan_mux_n #(.WIDTH(8), .CHANNELS(8), .SEL_W(3), .DIV_W(16)) u8 (
        .clk(clk), .rst(rst), .mode(mode8), .sel_in(sel_in8), .div_val(div8),
        .freeze(freeze8), .din(din8), .dout(dout8), .sel_out(sel8),
        .chan_onehot(oh8), .wrap(wrap8), .sel_err(err8)
    );

    scan_mux_n #(.WIDTH(8), .CHANNELS(6), .SEL_W(3), .DIV_W(16)) u6 (
        .clk(clk), .rst(rst), .mode(mode6), .sel_in(sel_in6), .div_val(div6),
        .freeze(freeze6), .din(din6), .dout(dout6), .sel_out(sel6),
        .chan_onehot(oh6), .wrap(wrap6), .sel_err(err6)
    );

    scan_mux_n #(.WIDTH(8), .CHANNELS(5), .SEL_W(3), .DIV_W(16)) u5 (
        .clk(clk), .rst(rst), .mode(mode5), .sel_in(sel_in5), .div_val(div5),
        .freeze(freeze5), .din(din5), .dout(dout5), .sel_out(sel5),
        .chan_onehot(oh5), .wrap(wrap5), .sel_err(err5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        mode8 = 1'b0; freeze8 = 1'b0; sel_in8 = 3'd0; div8 = 16'd0;
        mode6 = 1'b0; freeze6 = 1'b0; sel_in6 = 3'd0; div6 = 16'd0;
        mode5 = 1'b0; freeze5 = 1'b0; sel_in5 = 3'd0; div5 = 16'd0;
        for (int k = 0; k < 8; k++) din8[k*8 +: 8] = 8'(8'h10 + k);
        for (int k = 0; k < 6; k++) din6[k*8 +: 8] = 8'(8'h20 + k);
        for (int k = 0; k < 5; k++) din5[k*8 +: 8] = 8'(8'h30 + k);

        // Reset state
        #2 rst = 1'b1;
        #10;
        chk("rst_dout", 32'(dout8), 32'h0);
        chk("rst_sel", 32'(sel8), 32'h0);
        chk("rst_onehot", 32'(oh8), 32'h1);
        chk("rst_wrap", 32'(wrap8), 32'h0);
        chk("rst_err", 32'(err8), 32'h0);
        chk("rst_onehot5", 32'(oh5), 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Manual select on 8 channels
        sel_in8 = 3'd5;
        tick();
        chk("man8_dout", 32'(dout8), 32'h15);
        chk("man8_sel", 32'(sel8), 32'd5);
        chk("man8_onehot", 32'(oh8), 32'h20);
        chk("man8_err", 32'(err8), 32'h0);

        // Out-of-range manual select on 6 channels
        sel_in6 = 3'd3;
        tick();
        chk("man6_sel3", 32'(sel6), 32'd3);
        chk("man6_dout3", 32'(dout6), 32'h23);
        chk("man6_err_ok", 32'(err6), 32'h0);
        sel_in6 = 3'd7;
        tick();
        chk("man6_err7", 32'(err6), 32'h1);
        chk("man6_hold_sel", 32'(sel6), 32'd3);
        chk("man6_hold_dout", 32'(dout6), 32'h23);
        chk("man6_hold_oh", 32'(oh6), 32'h08);
        sel_in6 = 3'd6;
        tick();
        chk("man6_err6", 32'(err6), 32'h1);
        chk("man6_hold_sel6", 32'(sel6), 32'd3);
        sel_in6 = 3'd2;
        tick();
        chk("man6_err_clr", 32'(err6), 32'h0);
        chk("man6_sel2", 32'(sel6), 32'd2);
        chk("man6_dout2", 32'(dout6), 32'h22);

        // Auto scan, div_val=0, 5 channels
        sel_in5 = 3'd0;
        tick();
        mode5 = 1'b1;
        div5 = 16'd0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("auto5_sel_%0d", i), 32'(sel5), 32'(i % 5));
            chk($sformatf("auto5_wrap_%0d", i), 32'(wrap5), 32'((i % 5) == 0));
            chk($sformatf("auto5_dout_%0d", i), 32'(dout5), 32'(8'h30 + (i % 5)));
        end
        sel_in5 = 3'd7;
        tick();
        chk("auto5_no_err", 32'(err5), 32'h0);

        // Auto -> manual takes sel_in on the same edge
        mode5 = 1'b0;
        sel_in5 = 3'd3;
        tick();
        chk("a2m5_sel", 32'(sel5), 32'd3);
        chk("a2m5_dout", 32'(dout5), 32'h33);
        chk("a2m5_wrap", 32'(wrap5), 32'h0);

        // Lowering div_val below the running count advances on the next edge
        mode5 = 1'b1;
        div5 = 16'd5;
        tick(); tick(); tick();
        chk("lower5_hold", 32'(sel5), 32'd3);
        div5 = 16'd1;
        tick();
        chk("lower5_step", 32'(sel5), 32'd4);

        // Auto scan, div_val=2, 8 channels, starting from channel 0
        sel_in8 = 3'd0;
        tick();
        mode8 = 1'b1;
        div8 = 16'd2;
        for (int i = 1; i <= 24; i++) begin
            tick();
            chk($sformatf("auto8_sel_%0d", i), 32'(sel8), 32'((i / 3) % 8));
            chk($sformatf("auto8_wrap_%0d", i), 32'(wrap8), 32'((i % 24) == 0));
        end

        // Freeze with count=1: din of held channel keeps flowing through
        tick();
        chk("frz_pre_sel", 32'(sel8), 32'd0);
        freeze8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din8[7:0] = 8'(8'hA0 + i);
            tick();
            chk($sformatf("frz_sel_%0d", i), 32'(sel8), 32'd0);
            chk($sformatf("frz_dout_%0d", i), 32'(dout8), 32'(8'hA0 + i));
        end
        freeze8 = 1'b0;
        din8[7:0] = 8'h10;
        tick();
        chk("resume_hold", 32'(sel8), 32'd0);
        tick();
        chk("resume_step", 32'(sel8), 32'd1);
        chk("resume_dout", 32'(dout8), 32'h11);

        // Reach channel 4 with count 1, then assert reset between edges
        for (int i = 0; i < 10; i++) tick();
        chk("pre_rst_sel", 32'(sel8), 32'd4);
        chk("pre_rst_dout", 32'(dout8), 32'h14);
        #2 rst = 1'b1;
        #1;
        chk("arst_dout", 32'(dout8), 32'h0);
        chk("arst_sel", 32'(sel8), 32'd0);
        chk("arst_onehot", 32'(oh8), 32'h1);
        chk("arst_wrap", 32'(wrap8), 32'h0);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_d1", 32'(sel8), 32'd0);
        chk("post_rst_wrap", 32'(wrap8), 32'h0);
        tick();
        chk("post_rst_d2", 32'(sel8), 32'd0);
        tick();
        chk("post_rst_step", 32'(sel8), 32'd1);
        chk("post_rst_oh", 32'(oh8), 32'h02);
        chk("post_rst_dout", 32'(dout8), 32'h11);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
